// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter/sequencer for a single-port word RAM.
// Define RAM_ARB_BYTE_WRITE_EN to enable per-byte read-merge-write; otherwise any nonzero strobe writes the full word.
module ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  m0_valid,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_ready,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_valid,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_ready,
  output logic [31:0]           m1_rdata,
  output logic [1:0]            grant,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  last_m1_q, last_m1_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  m0_ready_q, m0_ready_d;
  logic                  m1_ready_q, m1_ready_d;
  logic                  pick_m1;
  logic [31:0]           merged;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_m1_d  = last_m1_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    pick_m1    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m0_valid || m1_valid) begin
          // On a tie the master not served last wins.
          pick_m1   = m1_valid && (!m0_valid || !last_m1_q);
          grant_d   = pick_m1 ? 2'b10 : 2'b01;
          last_m1_d = pick_m1;
          addr_d    = pick_m1 ? m1_addr  : m0_addr;
          wdata_d   = pick_m1 ? m1_wdata : m0_wdata;
          wstrb_d   = pick_m1 ? m1_wstrb : m0_wstrb;
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        rdata_d    = ram_rdata;
        m0_ready_d = grant_q[0];
        m1_ready_d = grant_q[1];
        state_d    = S_RESP;
      end
      S_RESP: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
`ifdef RAM_ARB_BYTE_WRITE_EN
    merged = ram_rdata;
    for (int unsigned i = 0; i < 4; i++) begin
      if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
`else
    merged = wdata_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      last_m1_q  <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_m1_q  <= last_m1_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
    end
  end

  // Write enable is gated by resetn so a reset edge during ACCESS suppresses the write.
  assign ram_wen     = resetn && (state_q == S_ACCESS) && (wstrb_q != 4'b0000);
  assign ram_wdata   = (state_q == S_ACCESS) ? merged : '0;
  assign ram_address = addr_q;
  assign grant       = grant_q;
  assign m0_ready    = m0_ready_q;
  assign m1_ready    = m1_ready_q;
  assign m0_rdata    = rdata_q;
  assign m1_rdata    = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-level reference model plus directed and random scenarios.
`timescale 1ns/1ps
module tb_ram_arbiter;

  logic        clk;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [11:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  grant;
  logic        ram_wen;
  logic [11:0] ram_address;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  // RAM behavioural model with a bench-side preload port
  logic [31:0] ram [0:1023];
  logic        pre_en;
  logic [9:0]  pre_idx;
  logic [31:0] pre_data;

  assign ram_rdata = ram[ram_address[11:2]];
  always @(posedge clk) begin
    if (ram_wen) ram[ram_address[11:2]] <= ram_wdata;
    if (pre_en) ram[pre_idx] <= pre_data;
  end

  ram_arbiter #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .grant(grant), .ram_wen(ram_wen), .ram_address(ram_address),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference: phase 0 free, 1 access, 2 response
  logic [31:0] mem_model [0:1023];
  int          ph = 0;
  bit          own = 1'b0;
  bit          lastm1 = 1'b1;
  logic [11:0] t_addr;
  logic [31:0] t_wdata;
  logic [3:0]  t_strb;
  logic [31:0] exp_rd = '0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
`ifdef RAM_ARB_BYTE_WRITE_EN
    logic [31:0] m;
    m = old;
    for (int i = 0; i < 4; i++) if (st[i]) m[8*i +: 8] = wd[8*i +: 8];
    return m;
`else
    return wd;
`endif
  endfunction

  task automatic model_edge();
    if (!resetn) begin
      ph = 0; own = 1'b0; lastm1 = 1'b1; exp_rd = '0;
    end else begin
      case (ph)
        0: if (m0_valid || m1_valid) begin
          own     = (m0_valid && m1_valid) ? !lastm1 : m1_valid;
          lastm1  = own;
          t_addr  = own ? m1_addr  : m0_addr;
          t_wdata = own ? m1_wdata : m0_wdata;
          t_strb  = own ? m1_wstrb : m0_wstrb;
          ph = 1;
        end
        1: begin
          exp_rd = mem_model[t_addr[11:2]];
          if (t_strb != 4'b0000) mem_model[t_addr[11:2]] = merge(exp_rd, t_wdata, t_strb);
          ph = 2;
        end
        default: ph = 0;
      endcase
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [11:0] addr, input logic [31:0] val);
    pre_en = 1'b1; pre_idx = addr[11:2]; pre_data = val;
    mem_model[addr[11:2]] = val;
    cyc();
    pre_en = 1'b0;
  endtask

  task automatic new_req(input int k);
    logic [11:0] a;
    logic [3:0]  s;
    a = {4'b0000, 6'($urandom_range(0, 63)), 2'($urandom)};
    s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
    if (k == 0) begin
      m0_valid = 1'b1; m0_addr = a; m0_wdata = $urandom; m0_wstrb = s;
    end else begin
      m1_valid = 1'b1; m1_addr = a; m1_wdata = $urandom; m1_wstrb = s;
    end
  endtask

  task automatic test_reset();
    m0_valid = 1'b1; m0_addr = 12'h004; m0_wstrb = 4'b0000; m0_wdata = '0;
    m1_valid = 1'b1; m1_addr = 12'h008; m1_wstrb = 4'b0000; m1_wdata = '0;
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
      checks++; if ({m0_ready, m1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {m0_ready, m1_ready}); end
      checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0", m0_rdata, m1_rdata); end
      checks++; if (ram_wen !== 1'b0 || ram_address !== 12'h0 || ram_wdata !== 32'h0) begin
        errors++; $display("FAIL reset_ram got wen=%b addr=%h wdata=%h want 0", ram_wen, ram_address, ram_wdata); end
    end
    resetn = 1'b1;
    cyc();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b want 01", grant); end
    cyc();
    checks++; if ({m1_ready, m0_ready} !== 2'b01) begin errors++; $display("FAIL reset_first_ready got %b want 01", {m1_ready, m0_ready}); end
    checks++; if (m0_rdata !== mem_model[1]) begin errors++; $display("FAIL reset_first_rdata got %h want %h", m0_rdata, mem_model[1]); end
    m0_valid = 1'b0; m1_valid = 1'b0;
    cyc();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_back_idle got %b want 00", grant); end
  endtask

  task automatic test_read();
    int rcnt = 0, wcnt = 0, at = 0;
    set_word(12'h010, 32'hDEADBEEF);
    m0_valid = 1'b1; m0_addr = 12'h010; m0_wstrb = 4'b0000; m0_wdata = $urandom;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (ram_wen) wcnt++;
      if (m0_ready) begin
        rcnt++; at = i; m0_valid = 1'b0;
        checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata got %h want deadbeef", m0_rdata); end
      end
    end
    checks++; if (rcnt != 1) begin errors++; $display("FAIL read_ready_count got %0d want 1", rcnt); end
    checks++; if (at != 2) begin errors++; $display("FAIL read_latency got %0d want 2", at); end
    checks++; if (wcnt != 0) begin errors++; $display("FAIL read_wen_count got %0d want 0", wcnt); end
  endtask

  task automatic test_byte_write();
    logic [31:0] want;
`ifdef RAM_ARB_BYTE_WRITE_EN
    want = 32'h11BB33DD;
`else
    want = 32'hAABBCCDD;
`endif
    set_word(12'h030, 32'h11223344);
    m1_valid = 1'b1; m1_addr = 12'h030; m1_wdata = 32'hAABBCCDD; m1_wstrb = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (m1_ready) begin
        m1_valid = 1'b0;
        checks++; if (m1_rdata !== 32'h11223344) begin errors++; $display("FAIL bytewr_rdata got %h want 11223344", m1_rdata); end
      end
    end
    checks++; if (ram[12] !== want) begin errors++; $display("FAIL bytewr_word got %h want %h", ram[12], want); end
  endtask

  task automatic test_back_to_back();
    int ev = 0, last_t = 0, n0 = 1, n1 = 1;
    resetn = 1'b0; cyc(); resetn = 1'b1;
    new_req(0); new_req(1);
    for (int t = 1; t <= 40; t++) begin
      cyc();
      if (m0_ready && m1_ready) begin errors++; checks++; $display("FAIL b2b_both_ready got 11 want one-hot"); end
      else if (m0_ready || m1_ready) begin
        checks++; if (m1_ready !== 1'(ev % 2)) begin errors++; $display("FAIL b2b_order event %0d got m%0d want m%0d", ev, m1_ready, ev % 2); end
        checks++; if (m0_rdata !== exp_rd) begin errors++; $display("FAIL b2b_rdata got %h want %h", m0_rdata, exp_rd); end
        if (ev > 0) begin
          checks++; if (t - last_t != 3) begin errors++; $display("FAIL b2b_spacing got %0d want 3", t - last_t); end
        end
        last_t = t; ev++;
        if (m0_ready) begin if (n0 < 4) begin new_req(0); n0++; end else m0_valid = 1'b0; end
        if (m1_ready) begin if (n1 < 4) begin new_req(1); n1++; end else m1_valid = 1'b0; end
      end
    end
    checks++; if (ev != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", ev); end
  endtask

  task automatic test_abort();
    set_word(12'h020, 32'h55667788);
    m1_valid = 1'b1; m1_addr = 12'h020; m1_wdata = 32'h0BADF00D; m1_wstrb = 4'hF;
    cyc();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL abort_grant got %b want 10", grant); end
    resetn = 1'b0;
    m0_valid = 1'b1; m0_addr = 12'h020; m0_wstrb = 4'b0000; m0_wdata = '0;
    #1;
    checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL abort_wen got %b want 0", ram_wen); end
    cyc();
    checks++; if (m1_ready !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL abort_state got ready=%b grant=%b want 0/00", m1_ready, grant); end
    checks++; if (ram[8] !== 32'h55667788) begin errors++; $display("FAIL abort_word got %h want 55667788", ram[8]); end
    resetn = 1'b1;
    cyc();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL abort_next_grant got %b want 01", grant); end
    cyc();
    checks++; if ({m1_ready, m0_ready} !== 2'b01) begin errors++; $display("FAIL abort_ready got %b want 01", {m1_ready, m0_ready}); end
    checks++; if (m0_rdata !== 32'h55667788) begin errors++; $display("FAIL abort_rdata got %h want 55667788", m0_rdata); end
    m0_valid = 1'b0; m1_valid = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_protocol_violation();
    int rcnt = 0;
    m0_valid = 1'b1; m0_addr = 12'h014; m0_wstrb = 4'b1000; m0_wdata = 32'hC0FFEE00;
    cyc();
    m0_valid = 1'b0;
    cyc();
    checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL proto_ready got %b want 1", m0_ready); end
    checks++; if (m0_rdata !== exp_rd) begin errors++; $display("FAIL proto_rdata got %h want %h", m0_rdata, exp_rd); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (m0_ready) rcnt++;
    end
    checks++; if (rcnt != 0 || grant !== 2'b00) begin errors++; $display("FAIL proto_idle got extra=%0d grant=%b want 0/00", rcnt, grant); end
  endtask

  task automatic test_random();
    logic [1:0] eg;
    bit         ew;
    for (int t = 0; t < 400; t++) begin
      cyc();
      eg = (ph == 0) ? 2'b00 : (own ? 2'b10 : 2'b01);
      ew = (ph == 1) && (t_strb != 4'b0000);
      checks++; if (grant !== eg) begin errors++; $display("FAIL rand_grant t=%0d got %b want %b", t, grant, eg); end
      checks++; if ({m1_ready, m0_ready} !== ((ph == 2) ? eg : 2'b00)) begin
        errors++; $display("FAIL rand_ready t=%0d got %b want %b", t, {m1_ready, m0_ready}, (ph == 2) ? eg : 2'b00); end
      checks++; if (ram_wen !== ew) begin errors++; $display("FAIL rand_wen t=%0d got %b want %b", t, ram_wen, ew); end
      if (ph == 1) begin
        checks++; if (ram_address !== t_addr) begin errors++; $display("FAIL rand_addr t=%0d got %h want %h", t, ram_address, t_addr); end
        if (ew) begin
          checks++; if (ram_wdata !== merge(mem_model[t_addr[11:2]], t_wdata, t_strb)) begin
            errors++; $display("FAIL rand_wdata t=%0d got %h want %h", t, ram_wdata, merge(mem_model[t_addr[11:2]], t_wdata, t_strb)); end
        end
      end
      if (ph == 2) begin
        checks++; if (m0_rdata !== exp_rd || m1_rdata !== exp_rd) begin
          errors++; $display("FAIL rand_rdata t=%0d got %h/%h want %h", t, m0_rdata, m1_rdata, exp_rd); end
      end
      if (m0_ready) begin m0_valid = 1'b0; if ($urandom_range(0, 2) != 0) new_req(0); end
      else if (!m0_valid && $urandom_range(0, 1) == 1) new_req(0);
      if (m1_ready) begin m1_valid = 1'b0; if ($urandom_range(0, 2) != 0) new_req(1); end
      else if (!m1_valid && $urandom_range(0, 1) == 1) new_req(1);
    end
    // Let any in-flight transaction finish; a held valid is acceptable since both are dropped on ready
    for (int t = 0; t < 8; t++) begin
      cyc();
      if (m0_ready) m0_valid = 1'b0;
      if (m1_ready) m1_valid = 1'b0;
    end
    for (int i = 0; i < 64; i++) begin
      checks++; if (ram[i] !== mem_model[i]) begin errors++; $display("FAIL rand_mem word %0d got %h want %h", i, ram[i], mem_model[i]); end
    end
  endtask

  initial begin
    resetn = 1'b0; pre_en = 1'b0; pre_idx = '0; pre_data = '0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    #2;
    for (int i = 0; i < 64; i++) set_word(12'(i * 4), $urandom);
    test_reset();
    test_read();
    test_byte_write();
    test_back_to_back();
    test_abort();
    test_protocol_violation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
